// File: rtl/pipelined_subtractor_if.sv
// Operand/result handshake bundle for the pipelined subtractor.
// The block is the slave on both sides; the producer/consumer pair is the master.
interface pipelined_subtractor_if #(
   parameter int WIDTH = 13
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             borrow;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, diff, borrow
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, diff, borrow
   );
endinterface

// File: rtl/pipelined_subtractor.sv
// Three-stage 13-bit unsigned subtractor (a + ~b + 1), sliced 4/4/5 bits per stage,
// with a single global stall driven by the output handshake.
module pipelined_subtractor #(
   parameter int WIDTH = 13
) (
   input logic                  clk,
   input logic                  rst,
   pipelined_subtractor_if.slave bus
);
   localparam int HI    = WIDTH - 8;
   localparam int UPPER = WIDTH - 4;

   logic             w_adv;
   logic [4:0]       w_sum0;
   logic [4:0]       w_sum1;
   logic [HI:0]      w_sum2;

   logic             r_v1;
   logic             r_v2;
   logic             r_v3;

   logic [3:0]       r_diff1;
   logic             r_c1;
   logic [UPPER-1:0] r_aHi1;
   logic [UPPER-1:0] r_bnHi1;

   logic [7:0]       r_diff2;
   logic             r_c2;
   logic [HI-1:0]    r_aHi2;
   logic [HI-1:0]    r_bnHi2;

   logic [WIDTH-1:0] r_diff3;
   logic             r_borrow;

   // The whole pipe moves together; only a full, blocked last stage stalls it.
   assign w_adv        = ~r_v3 | bus.out_ready;
   assign bus.in_ready = w_adv;

   always_comb begin
      w_sum0 = {1'b0, bus.a[3:0]} + {1'b0, ~bus.b[3:0]} + 5'd1;
      w_sum1 = {1'b0, r_aHi1[3:0]} + {1'b0, r_bnHi1[3:0]} + {4'd0, r_c1};
      w_sum2 = {1'b0, r_aHi2} + {1'b0, r_bnHi2} + {{HI{1'b0}}, r_c2};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_v1 <= 1'b0;
         r_v2 <= 1'b0;
         r_v3 <= 1'b0;
      end else if (w_adv) begin
         r_v1 <= bus.in_valid;
         r_v2 <= r_v1;
         r_v3 <= r_v2;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_diff1 <= '0;
         r_c1    <= 1'b0;
         r_aHi1  <= '0;
         r_bnHi1 <= '0;
      end else if (w_adv) begin
         r_diff1 <= w_sum0[3:0];
         r_c1    <= w_sum0[4];
         r_aHi1  <= bus.a[WIDTH-1:4];
         r_bnHi1 <= ~bus.b[WIDTH-1:4];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_diff2 <= '0;
         r_c2    <= 1'b0;
         r_aHi2  <= '0;
         r_bnHi2 <= '0;
      end else if (w_adv) begin
         r_diff2 <= {w_sum1[3:0], r_diff1};
         r_c2    <= w_sum1[4];
         r_aHi2  <= r_aHi1[UPPER-1:4];
         r_bnHi2 <= r_bnHi1[UPPER-1:4];
      end
   end

   // A missing final carry means the subtrahend was larger.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_diff3  <= '0;
         r_borrow <= 1'b0;
      end else if (w_adv) begin
         r_diff3  <= {w_sum2[HI-1:0], r_diff2};
         r_borrow <= ~w_sum2[HI];
      end
   end

   assign bus.out_valid = r_v3;
   assign bus.diff      = r_diff3;
   assign bus.borrow    = r_borrow;
endmodule

// File: tb/tb_pipelined_subtractor.sv
// Directed and randomized checks of the pipelined subtractor: latency, wrap,
// streaming, back-pressure, mid-flight reset and a long scoreboarded run.
module tb_pipelined_subtractor;
   logic clk = 1'b0;
   logic rst;
   int   nCompared   = 0;
   int   nMismatched = 0;

   pipelined_subtractor_if #(.WIDTH(13)) bus ();

   pipelined_subtractor #(.WIDTH(13)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid  = 1'b1;
      bus.a         = 13'h0007;
      bus.b         = 13'h0001;
      bus.out_ready = 1'b1;
      step();
      step();
      nCompared++;
      if (bus.out_valid !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid);
      end
      nCompared++;
      if (bus.diff !== 13'h0000) begin
         nMismatched++;
         $display("[TB] FAIL reset_diff: got %h expected 0000", bus.diff);
      end
      nCompared++;
      if (bus.borrow !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL reset_borrow: got %b expected 0", bus.borrow);
      end
      nCompared++;
      if (bus.in_ready !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready);
      end
      rst = 1'b0;
      bus.in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         nCompared++;
         if (bus.out_valid !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_not_captured: cycle %0d got out_valid %b expected 0", i, bus.out_valid);
         end
      end
   endtask

   task automatic test_single();
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.a         = 13'h0005;
      bus.b         = 13'h0003;
      step();
      bus.in_valid = 1'b0;
      step();
      nCompared++;
      if (bus.out_valid !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL single_early: got out_valid %b expected 0", bus.out_valid);
      end
      step();
      nCompared++;
      if (bus.out_valid !== 1'b1) begin
         nMismatched++;
         $display("[TB] FAIL single_valid: got %b expected 1", bus.out_valid);
      end
      nCompared++;
      if (bus.diff !== 13'h0002 || bus.borrow !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL single_result: got diff %h borrow %b expected 0002 0", bus.diff, bus.borrow);
      end
      step();
      nCompared++;
      if (bus.out_valid !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL single_one_cycle: got out_valid %b expected 0", bus.out_valid);
      end
   endtask

   task automatic test_wrap();
      logic [12:0] va [5];
      logic [12:0] vb [5];
      logic [12:0] vd [5];
      logic        vbr[5];
      va[0] = 13'h0000; vb[0] = 13'h0001; vd[0] = 13'h1FFF; vbr[0] = 1'b1;
      va[1] = 13'h1FFF; vb[1] = 13'h1FFF; vd[1] = 13'h0000; vbr[1] = 1'b0;
      va[2] = 13'h0100; vb[2] = 13'h00FF; vd[2] = 13'h0001; vbr[2] = 1'b0;
      va[3] = 13'h1000; vb[3] = 13'h0001; vd[3] = 13'h0FFF; vbr[3] = 1'b0;
      va[4] = 13'h0ABC; vb[4] = 13'h0ABD; vd[4] = 13'h1FFF; vbr[4] = 1'b1;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = 1'b1;
         bus.a        = va[i];
         bus.b        = vb[i];
         step();
         bus.in_valid = 1'b0;
         step();
         step();
         nCompared++;
         if (bus.out_valid !== 1'b1 || bus.diff !== vd[i] || bus.borrow !== vbr[i]) begin
            nMismatched++;
            $display("[TB] FAIL wrap_%0d: got valid %b diff %h borrow %b expected 1 %h %b",
                     i, bus.out_valid, bus.diff, bus.borrow, vd[i], vbr[i]);
         end
      end
      step();
   endtask

   task automatic test_streaming();
      logic [12:0] expDiff[8];
      logic        expBorrow[8];
      int          k = 0;
      expDiff[0] = 13'h1C00; expBorrow[0] = 1'b1;
      expDiff[1] = 13'h1D23; expBorrow[1] = 1'b1;
      expDiff[2] = 13'h1E46; expBorrow[2] = 1'b1;
      expDiff[3] = 13'h1F69; expBorrow[3] = 1'b1;
      expDiff[4] = 13'h008C; expBorrow[4] = 1'b0;
      expDiff[5] = 13'h01AF; expBorrow[5] = 1'b0;
      expDiff[6] = 13'h02D2; expBorrow[6] = 1'b0;
      expDiff[7] = 13'h03F5; expBorrow[7] = 1'b0;
      bus.out_ready = 1'b1;
      for (int cyc = 0; cyc < 14; cyc++) begin
         bus.in_valid = (cyc < 8);
         bus.a        = 13'(cyc * 13'h0123);
         bus.b        = 13'h0400;
         #1;
         nCompared++;
         if (bus.in_ready !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL stream_in_ready: cycle %0d got %b expected 1", cyc, bus.in_ready);
         end
         step();
         if (bus.out_valid === 1'b1) begin
            nCompared++;
            if (k >= 8 || cyc !== k + 2 || bus.diff !== expDiff[k[2:0]] || bus.borrow !== expBorrow[k[2:0]]) begin
               nMismatched++;
               $display("[TB] FAIL stream_result_%0d: cycle %0d got diff %h borrow %b expected cycle %0d diff %h borrow %b",
                        k, cyc, bus.diff, bus.borrow, k + 2, expDiff[k[2:0]], expBorrow[k[2:0]]);
            end
            k++;
         end
      end
      nCompared++;
      if (k !== 8) begin
         nMismatched++;
         $display("[TB] FAIL stream_count: got %0d results expected 8", k);
      end
   endtask

   task automatic test_back_pressure();
      logic [13:0] expQ[$];
      logic [13:0] front;
      logic [12:0] heldDiff = '0;
      int          j = 0;
      int          got = 0;
      logic        expReady;
      for (int cyc = 0; cyc < 20; cyc++) begin
         bus.out_ready = !(cyc >= 3 && cyc <= 6);
         bus.in_valid  = (j < 6);
         bus.a         = 13'(13'h0100 + j * 13'h0111);
         bus.b         = 13'h0155;
         #1;
         expReady = !(cyc >= 3 && cyc <= 6);
         nCompared++;
         if (bus.in_ready !== expReady) begin
            nMismatched++;
            $display("[TB] FAIL bp_in_ready: cycle %0d got %b expected %b", cyc, bus.in_ready, expReady);
         end
         if (cyc == 3) heldDiff = bus.diff;
         if (cyc >= 4 && cyc <= 6) begin
            nCompared++;
            if (bus.out_valid !== 1'b1 || bus.diff !== heldDiff) begin
               nMismatched++;
               $display("[TB] FAIL bp_hold: cycle %0d got valid %b diff %h expected 1 %h",
                        cyc, bus.out_valid, bus.diff, heldDiff);
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            expQ.push_back({bus.a < bus.b, 13'(bus.a - bus.b)});
            j++;
         end
         if (bus.out_valid && bus.out_ready) begin
            nCompared++;
            front = (expQ.size() > 0) ? expQ.pop_front() : 14'h3FFF;
            if ({bus.borrow, bus.diff} !== front) begin
               nMismatched++;
               $display("[TB] FAIL bp_result_%0d: got borrow %b diff %h expected %b %h",
                        got, bus.borrow, bus.diff, front[13], front[12:0]);
            end
            got++;
         end
         step();
      end
      bus.in_valid = 1'b0;
      nCompared++;
      if (got !== 6 || expQ.size() !== 0) begin
         nMismatched++;
         $display("[TB] FAIL bp_count: got %0d results, %0d pending, expected 6 and 0", got, expQ.size());
      end
   endtask

   task automatic test_reset_midflight();
      bus.out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         bus.in_valid = 1'b1;
         bus.a        = 13'(13'h0020 + k);
         bus.b        = 13'h0001;
         step();
      end
      nCompared++;
      if (bus.out_valid !== 1'b1 || bus.diff !== 13'h001F) begin
         nMismatched++;
         $display("[TB] FAIL mid_full: got valid %b diff %h expected 1 001F", bus.out_valid, bus.diff);
      end
      bus.in_valid = 1'b0;
      rst = 1'b1;
      step();
      nCompared++;
      if (bus.out_valid !== 1'b0 || bus.diff !== 13'h0000 || bus.borrow !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL mid_reset: got valid %b diff %h borrow %b expected 0 0000 0",
                  bus.out_valid, bus.diff, bus.borrow);
      end
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         nCompared++;
         if (bus.out_valid !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL mid_discard: cycle %0d got out_valid %b expected 0", i, bus.out_valid);
         end
      end
      bus.in_valid = 1'b1;
      bus.a        = 13'h0010;
      bus.b        = 13'h0001;
      step();
      bus.in_valid = 1'b0;
      step();
      step();
      nCompared++;
      if (bus.out_valid !== 1'b1 || bus.diff !== 13'h000F || bus.borrow !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL mid_post_op: got valid %b diff %h borrow %b expected 1 000F 0",
                  bus.out_valid, bus.diff, bus.borrow);
      end
      step();
   endtask

   task automatic test_random();
      logic [13:0] expQ[$];
      logic [13:0] front;
      int          sent = 0;
      int          recv = 0;
      int          cyc  = 0;
      int          badCount = 0;
      logic        accepted;
      bus.in_valid = 1'b0;
      while (recv < 10000 && cyc < 60000) begin
         if (!bus.in_valid && sent < 10000 && $urandom_range(3) != 0) begin
            bus.in_valid = 1'b1;
            bus.a        = 13'($urandom);
            bus.b        = 13'($urandom);
         end
         bus.out_ready = ($urandom_range(3) != 0);
         #1;
         accepted = bus.in_valid && bus.in_ready;
         if (accepted) begin
            expQ.push_back({bus.a < bus.b, 13'(bus.a - bus.b)});
            sent++;
         end
         if (bus.out_valid && bus.out_ready) begin
            nCompared++;
            front = (expQ.size() > 0) ? expQ.pop_front() : 14'h3FFF;
            if ({bus.borrow, bus.diff} !== front) begin
               nMismatched++;
               if (badCount < 10)
                  $display("[TB] FAIL rand_result_%0d: got borrow %b diff %h expected %b %h",
                           recv, bus.borrow, bus.diff, front[13], front[12:0]);
               badCount++;
            end
            recv++;
         end
         step();
         if (accepted) bus.in_valid = 1'b0;
         cyc++;
      end
      bus.in_valid = 1'b0;
      nCompared++;
      if (recv !== 10000 || expQ.size() !== 0) begin
         nMismatched++;
         $display("[TB] FAIL rand_complete: got %0d results, %0d pending, expected 10000 and 0", recv, expQ.size());
      end
   endtask

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.out_ready = 1'b1;
      test_reset();
      test_single();
      test_wrap();
      test_streaming();
      test_back_pressure();
      test_reset_midflight();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end
endmodule
